// File: rtl/cover_eval_sched.sv
// rtl/cover_eval_sched.sv - point buffer plus round-robin scheduled disc-coverage evaluator
//
// Buffers N_PTS 4-bit (x,y) points, then serves coverage requests from N_REQ
// search engines. Each accepted request scans every stored point against one
// candidate center, PAR points per cycle, and returns the hit mask together
// with popcount(hit | pre-covered mask).
//
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   CLR                synchronous flush: drop buffer and any evaluation, reload
//   LD_VALID/LD_X/LD_Y point load stream, accepted only while loading
//   LOADED             buffer full, service enabled
//   REQ_VALID/READY    per-requester handshake, READY one-hot or zero
//   REQ_CX/CY/MASK     per-requester candidate center and pre-covered mask
//   RSP_VALID          one-cycle response strobe
//   RSP_ID/HIT/COUNT   response payload, held until the next response
module cover_eval_sched #(
    parameter int N_PTS = 40,
    parameter int PAR   = 5,
    parameter int N_REQ = 2,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW   = $clog2(N_PTS + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLR,
    input  logic                     LD_VALID,
    input  logic [3:0]               LD_X,
    input  logic [3:0]               LD_Y,
    output logic                     LOADED,
    input  logic [N_REQ-1:0]         REQ_VALID,
    output logic [N_REQ-1:0]         REQ_READY,
    input  logic [4*N_REQ-1:0]       REQ_CX,
    input  logic [4*N_REQ-1:0]       REQ_CY,
    input  logic [N_PTS*N_REQ-1:0]   REQ_MASK,
    output logic                     RSP_VALID,
    output logic [IDW-1:0]           RSP_ID,
    output logic [N_PTS-1:0]         RSP_HIT,
    output logic [CW-1:0]            RSP_COUNT
);

    localparam int LCW = $clog2(N_PTS + 1);

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        IDLE = 3'd1,
        SCAN = 3'd2,
        SUM  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [LCW-1:0]     load_cnt;
    logic [7:0]         pts [N_PTS];
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;
    logic               accept;
    logic [IDW-1:0]     cap_id;
    logic [3:0]         cap_cx;
    logic [3:0]         cap_cy;
    logic [N_PTS-1:0]   cap_mask;
    logic [N_PTS-1:0]   hit;
    logic [LCW-1:0]     scan_idx;
    logic [PAR-1:0]     in_blk;
    logic [CW-1:0]      popcnt;

    // Squared-distance test with no coordinate wrap: |0-15| is 15.
    function automatic logic in_disc(input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] px, input logic [3:0] py);
        logic [9:0] dx;
        logic [9:0] dy;
        dx = (cx >= px) ? {6'd0, cx - px} : {6'd0, px - cx};
        dy = (cy >= py) ? {6'd0, cy - py} : {6'd0, py - cy};
        return (dx * dx + dy * dy) <= 10'd16;
    endfunction

    // Round-robin search starting at rr_ptr, wrapping once around.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && REQ_VALID[(int'(rr_ptr) + k) % N_REQ]) begin
                grant_any = 1'b1;
                grant_id  = IDW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // CLR masks READY so a flush cycle can never look like an accept.
    assign accept = (state == IDLE) && !CLR && grant_any;

    always_comb begin
        REQ_READY = '0;
        if (accept) begin
            REQ_READY[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (LD_VALID && load_cnt == LCW'(N_PTS - 1)) state_nx = IDLE;
            IDLE: if (accept) state_nx = SCAN;
            SCAN: if (scan_idx == LCW'(N_PTS - PAR)) state_nx = SUM;
            SUM:  state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = LOAD;
        endcase
        if (CLR) begin
            state_nx = LOAD;
        end
    end

    always_comb begin
        in_blk = '0;
        for (int j = 0; j < PAR; j++) begin
            in_blk[j] = in_disc(cap_cx, cap_cy,
                                pts[scan_idx + LCW'(j)][3:0],
                                pts[scan_idx + LCW'(j)][7:4]);
        end
    end

    always_comb begin
        popcnt = '0;
        for (int k = 0; k < N_PTS; k++) begin
            popcnt = popcnt + CW'(hit[k] | cap_mask[k]);
        end
    end

    // Point storage has no reset; its contents are only meaningful once LOADED.
    always_ff @(posedge CLK) begin
        if (!CLR && state == LOAD && LD_VALID) begin
            pts[load_cnt] <= {LD_Y, LD_X};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= LOAD;
            load_cnt  <= '0;
            rr_ptr    <= '0;
            LOADED    <= 1'b0;
            cap_id    <= '0;
            cap_cx    <= '0;
            cap_cy    <= '0;
            cap_mask  <= '0;
            hit       <= '0;
            scan_idx  <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_HIT   <= '0;
            RSP_COUNT <= '0;
        end else begin
            state     <= state_nx;
            RSP_VALID <= 1'b0;
            if (CLR) begin
                load_cnt <= '0;
                LOADED   <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (LD_VALID) begin
                            load_cnt <= load_cnt + 1'b1;
                            if (load_cnt == LCW'(N_PTS - 1)) begin
                                LOADED <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        if (grant_any) begin
                            cap_id   <= grant_id;
                            cap_cx   <= REQ_CX[int'(grant_id) * 4 +: 4];
                            cap_cy   <= REQ_CY[int'(grant_id) * 4 +: 4];
                            cap_mask <= REQ_MASK[int'(grant_id) * N_PTS +: N_PTS];
                            rr_ptr   <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                            hit      <= '0;
                            scan_idx <= '0;
                        end
                    end
                    SCAN: begin
                        hit[scan_idx +: PAR] <= in_blk;
                        scan_idx             <= scan_idx + LCW'(PAR);
                    end
                    SUM: begin
                        // Response registers load here so they hold after the strobe.
                        RSP_VALID <= 1'b1;
                        RSP_ID    <= cap_id;
                        RSP_HIT   <= hit;
                        RSP_COUNT <= popcnt;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
